fault_monitor: RTL and testbench
================================

Name: fault_monitor

Overview:
- Upstream stage of the power-unit init/LED block.
- Takes raw IGBT-driver, DC-bus, temperature and communication status and produces the eight latched fault flags consumed there.
- Debounces each raw condition on the 200 us tick, latches faults until an accepted clear request, and raises a trip that blocks the bridge.
- Reports which fault occurred first.

Parameters:
DEB_TICKS, 5, consecutive active tick samples before a raw condition latches (5 = 1 ms)
OV_TH, 12'd3500, DC-bus overvoltage threshold; ov condition is vdc > OV_TH
UV_TH, 12'd1200, DC-bus undervoltage threshold; uv condition is vdc < UV_TH
COMM_TO, 50, ticks without heartbeat before call_fault (50 = 10 ms)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
tri_200us  input  13  free-running 200 us phase counter; tick = (tri_200us == 13'h1), one clk wide
drv_flt_n  input  4  IGBT driver fault pins, active-low, bit0 maps to fault1
vdc  input  12  DC-bus ADC sample, unsigned
tem_n  input  1  over-temperature switch, active-low
hb  input  1  one-clk heartbeat pulse from the communication block
sysrdy  input  1  init complete; masks uv and comm checks while low
clr_req  input  1  one-clk fault clear request
fault1..fault4  output  1 each  latched driver faults
ov_fault, uv_fault, TEM_fault, call_fault  output  1 each  latched faults
trip  output  1  OR of all eight latches, registered
first_fault  output  4  code of first latched fault (1=fault1 … 8=call_fault, 0=none)
clr_ack  output  1  one-clk pulse when a clear is executed
clr_nack  output  1  one-clk pulse when a clear is refused

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On rst all latches, counters, first_fault, trip, clr_ack and clr_nack are 0. State is RUN.
- Raw conditions (active-high internally):
  - fault1..4 raw = ~drv_flt_n[i]
  - ov raw = vdc > OV_TH (strict)
  - uv raw = (vdc < UV_TH) & sysrdy
  - TEM raw = ~tem_n
- Debounce, per channel 1..7:
  - 3-bit counter, updated only on tick.
  - Raw active on tick: counter increments, saturating at DEB_TICKS.
  - Raw inactive on tick: counter clears to 0.
  - debounced = (counter == DEB_TICKS).
  - The latch sets on the same edge at which the counter reaches DEB_TICKS, so the flag is visible the clk after the DEB_TICKS-th consecutive active tick.
  - A glitch shorter than DEB_TICKS ticks never latches.
- Comm watchdog:
  - 6-bit tick counter, cleared by hb or while sysrdy=0.
  - Otherwise increments on tick, saturating at COMM_TO.
  - Reaching COMM_TO sets call_fault; its debounced status is (counter == COMM_TO).
  - hb and tick in the same clk: hb wins, counter goes to 0.
- Latches: set-only outside CLEAR state. trip = OR of latches, registered, 1 clk after the latch.
- first_fault:
  - Captured only while it is 0, at the edge where any latch first sets.
  - Simultaneous sets: lowest code wins.
  - Holds until a clear is executed.
- State machine:
  - RUN: trip=0. Any latch set -> TRIP.
  - TRIP, clr_req and all eight debounced statuses 0 -> CLEAR.
  - TRIP, clr_req and any debounced status 1 -> clr_nack pulse, stay in TRIP, latches unchanged.
  - CLEAR (exactly 1 clk): latches, first_fault and all debounce counters clear; clr_ack pulses. Next state RUN.
  - clr_req in RUN or CLEAR: ignored, no ack, no nack.
- A new raw condition during CLEAR is not lost: its counter restarts from 0 and re-latches after DEB_TICKS ticks.
- rst mid-debounce or in TRIP returns everything to the reset values above.

Test Plan:
1. drv_flt_n[2]=0 for 5 ticks -> fault3=1 one clk after the 5th tick; trip=1 one clk later; first_fault=3. Same pin low for only 4 ticks -> fault3 stays 0.
2. vdc=3500 held 10 ticks -> ov_fault=0. vdc=3501 for 5 ticks -> ov_fault=1. vdc=1100 with sysrdy=0 for 20 ticks -> uv_fault=0; with sysrdy=1 -> uv_fault=1 after 5 ticks.
3. sysrdy=1, hb every 40 ticks -> call_fault=0. hb stopped -> call_fault=1 at 50 ticks after the last hb. hb coincident with tick -> counter=0.
4. tem_n and drv_flt_n[0] go low on the same clk for 5 ticks -> TEM_fault=1 and fault1=1 on the same edge; first_fault=1.
5. In TRIP with tem_n still low, clr_req -> clr_nack=1 for 1 clk, latches held. After tem_n high for ≥1 tick, clr_req -> clr_ack=1, all flags 0, first_fault=0, trip=0 the following clk, state RUN.
6. rst asserted for 1 clk while in TRIP with counters non-zero -> all outputs 0 the next clk; a 3-tick fault after rst does not latch.

Source files
------------

// File: rtl/fault_monitor_if.sv
// Status-in / fault-out bundle between the power-stage sensors and the fault monitor.
// The monitor uses the slave view; the stimulus side (or upstream logic) uses the master view.
interface fault_monitor_if;
    logic [12:0] tri_200us;
    logic [3:0]  drv_flt_n;
    logic [11:0] vdc;
    logic        tem_n;
    logic        hb;
    logic        sysrdy;
    logic        clr_req;

    logic        fault1;
    logic        fault2;
    logic        fault3;
    logic        fault4;
    logic        ov_fault;
    logic        uv_fault;
    logic        TEM_fault;
    logic        call_fault;
    logic        trip;
    logic [3:0]  first_fault;
    logic        clr_ack;
    logic        clr_nack;

    modport master (
        output tri_200us, drv_flt_n, vdc, tem_n, hb, sysrdy, clr_req,
        input  fault1, fault2, fault3, fault4, ov_fault, uv_fault, TEM_fault, call_fault,
        input  trip, first_fault, clr_ack, clr_nack
    );

    modport slave (
        input  tri_200us, drv_flt_n, vdc, tem_n, hb, sysrdy, clr_req,
        output fault1, fault2, fault3, fault4, ov_fault, uv_fault, TEM_fault, call_fault,
        output trip, first_fault, clr_ack, clr_nack
    );
endinterface

// File: rtl/fault_monitor.sv
// Fault monitor: debounces raw power-stage conditions on the 200 us tick, latches them
// until an accepted clear, and reports trip plus the code of the first fault.

module fault_monitor_deb #(
    parameter int unsigned DEB_TICKS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_clr,
    input  logic i_raw,
    output logic o_deb,
    output logic o_hit
);
    localparam logic [2:0] LP_DEB = 3'(DEB_TICKS);

    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_tick) begin
            if (!i_raw)                w_cnt_nxt = '0;
            else if (r_cnt != LP_DEB)  w_cnt_nxt = r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_nxt;
    end

    // o_hit looks at the next count so the latch sets on the edge the count saturates
    assign o_deb = (r_cnt == LP_DEB);
    assign o_hit = (w_cnt_nxt == LP_DEB);
endmodule

module fault_monitor #(
    parameter int unsigned DEB_TICKS = 5,
    parameter logic [11:0] OV_TH     = 12'd3500,
    parameter logic [11:0] UV_TH     = 12'd1200,
    parameter int unsigned COMM_TO   = 50
) (
    input  logic           clk,
    input  logic           rst,
    fault_monitor_if.slave bus
);
    localparam int         NUM_CH   = 7;
    localparam logic [5:0] LP_WD_TO = 6'(COMM_TO);

    typedef enum logic [1:0] {S_RUN, S_TRIP, S_CLEAR} state_t;

    state_t            r_state, w_state_nxt;
    logic              w_tick, w_clr;
    logic [NUM_CH-1:0] w_raw, w_deb_ch, w_hit_ch;
    logic [7:0]        w_deb, w_hit, w_set, r_latch;
    logic [5:0]        r_wd, w_wd_nxt;
    logic [3:0]        r_first, w_first_code;
    logic              r_trip, r_ack, r_nack, w_ack, w_nack;

    assign w_tick = (bus.tri_200us == 13'h1);
    assign w_clr  = (r_state == S_CLEAR);

    // channel order matches the first_fault code minus one
    assign w_raw = {~bus.tem_n,
                    (bus.vdc < UV_TH) & bus.sysrdy,
                    (bus.vdc > OV_TH),
                    ~bus.drv_flt_n};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
            fault_monitor_deb #(.DEB_TICKS(DEB_TICKS)) u_deb (
                .clk    (clk),
                .rst    (rst),
                .i_tick (w_tick),
                .i_clr  (w_clr),
                .i_raw  (w_raw[g]),
                .o_deb  (w_deb_ch[g]),
                .o_hit  (w_hit_ch[g])
            );
        end
    endgenerate

    // heartbeat wins over a coincident tick
    always_comb begin
        w_wd_nxt = r_wd;
        if (w_clr || bus.hb || !bus.sysrdy)     w_wd_nxt = '0;
        else if (w_tick && r_wd != LP_WD_TO)    w_wd_nxt = r_wd + 6'd1;
    end

    assign w_deb = {(r_wd == LP_WD_TO), w_deb_ch};
    assign w_hit = {(w_wd_nxt == LP_WD_TO), w_hit_ch};
    assign w_set = w_clr ? 8'h00 : (w_hit & ~r_latch);

    always_comb begin
        w_first_code = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_set[i]) w_first_code = 4'(i + 1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_nack      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (|r_latch) w_state_nxt = S_TRIP;
            end
            S_TRIP: begin
                if (bus.clr_req) begin
                    if (|w_deb) begin
                        w_nack = 1'b1;
                    end else begin
                        w_state_nxt = S_CLEAR;
                        w_ack       = 1'b1;
                    end
                end
            end
            S_CLEAR: w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_latch <= '0;
            r_trip  <= 1'b0;
            r_first <= '0;
            r_ack   <= 1'b0;
            r_nack  <= 1'b0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_latch <= w_clr ? 8'h00 : (r_latch | w_hit);
            r_trip  <= w_clr ? 1'b0 : (|r_latch);
            r_ack   <= w_ack;
            r_nack  <= w_nack;
            r_wd    <= w_wd_nxt;
            if (w_clr)                          r_first <= '0;
            else if (r_first == 4'd0 && |w_set) r_first <= w_first_code;
        end
    end

    assign bus.fault1      = r_latch[0];
    assign bus.fault2      = r_latch[1];
    assign bus.fault3      = r_latch[2];
    assign bus.fault4      = r_latch[3];
    assign bus.ov_fault    = r_latch[4];
    assign bus.uv_fault    = r_latch[5];
    assign bus.TEM_fault   = r_latch[6];
    assign bus.call_fault  = r_latch[7];
    assign bus.trip        = r_trip;
    assign bus.first_fault = r_first;
    assign bus.clr_ack     = r_ack;
    assign bus.clr_nack    = r_nack;
endmodule

// File: tb/tb_fault_monitor.sv
// Bench for fault_monitor: directed scenario tasks plus a random soak, all checked
// against an integer-counting behavioural model of the fault rules.
module tb_fault_monitor;
    localparam int PER     = 10;
    localparam int DEB     = 5;
    localparam int COMM_TO = 50;

    logic clk;
    logic rst;
    fault_monitor_if bus();

    fault_monitor dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp;
    int n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.tri_200us = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.tri_200us = (bus.tri_200us == 13'(PER - 1)) ? 13'd0 : bus.tri_200us + 13'd1;
        end
    end

    // ---------------- behavioural model ----------------
    int         run[7];
    int         since;
    int         m_state;    // 0 run, 1 tripped, 2 clearing
    logic [7:0] m_lat, hits, newf, odeb;
    logic [6:0] mraw;
    logic [3:0] m_ff;
    logic       m_trip, m_ack, m_nack, tk, wclr;

    initial begin
        m_lat = '0; m_ff = '0; m_trip = 0; m_ack = 0; m_nack = 0; m_state = 0; since = 0;
        foreach (run[c]) run[c] = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_lat = '0; m_ff = '0; m_trip = 0; m_ack = 0; m_nack = 0; m_state = 0; since = 0;
            foreach (run[c]) run[c] = 0;
        end else begin
            tk = (bus.tri_200us == 13'd1);
            for (int c = 0; c < 7; c++) odeb[c] = (run[c] >= DEB);
            odeb[7] = (since >= COMM_TO);
            wclr    = (m_state == 2);
            m_ack   = 0;
            m_nack  = 0;
            m_trip  = wclr ? 1'b0 : (m_lat != 0);
            if (m_state == 0) begin
                if (m_lat != 0) m_state = 1;
            end else if (m_state == 1) begin
                if (bus.clr_req) begin
                    if (odeb != 0) m_nack = 1;
                    else begin m_state = 2; m_ack = 1; end
                end
            end else begin
                m_state = 0;
            end
            if (wclr) begin
                m_lat = '0; m_ff = '0; since = 0;
                foreach (run[c]) run[c] = 0;
            end else begin
                mraw[3:0] = ~bus.drv_flt_n;
                mraw[4]   = (int'(bus.vdc) > 3500);
                mraw[5]   = (int'(bus.vdc) < 1200) && bus.sysrdy;
                mraw[6]   = ~bus.tem_n;
                for (int c = 0; c < 7; c++) begin
                    if (tk) run[c] = mraw[c] ? run[c] + 1 : 0;
                    hits[c] = (run[c] >= DEB);
                end
                if (bus.hb || !bus.sysrdy) since = 0;
                else if (tk) since = since + 1;
                hits[7] = (since >= COMM_TO);
                newf = hits & ~m_lat;
                if (m_ff == 0)
                    for (int c = 7; c >= 0; c--) if (newf[c]) m_ff = 4'(c + 1);
                m_lat = m_lat | hits;
            end
        end
    end

    logic [7:0]  dut_lat;
    logic [14:0] dut_all, mdl_all;
    assign dut_lat = {bus.call_fault, bus.TEM_fault, bus.uv_fault, bus.ov_fault,
                      bus.fault4, bus.fault3, bus.fault2, bus.fault1};
    assign dut_all = {dut_lat, bus.trip, bus.first_fault, bus.clr_ack, bus.clr_nack};
    assign mdl_all = {m_lat, m_trip, m_ff, m_ack, m_nack};

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // advance until n tick edges have been sampled; returns just after the last one
    task automatic tick_edges(input int n);
        for (int k = 0; k < n; k++) begin
            while (bus.tri_200us != 13'd1) cyc();
            cyc();
        end
    endtask

    task automatic clear_faults(input string tag);
        tick_edges(1);
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        n_cmp++;
        if (bus.clr_ack !== 1'b1 || dut_all !== mdl_all) begin
            n_bad++;
            $display("FAIL %s_ack ack=%b all=%h exp ack=1 all=%h", tag, bus.clr_ack, dut_all, mdl_all);
        end
        cyc();
        n_cmp++;
        if (dut_lat !== 8'h00 || bus.trip !== 1'b0 || bus.first_fault !== 4'd0 || dut_all !== mdl_all) begin
            n_bad++;
            $display("FAIL %s_cleared all=%h exp=%h", tag, dut_all, mdl_all);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.drv_flt_n = 4'hF; bus.vdc = 12'd2000; bus.tem_n = 1'b1;
        bus.hb = 1'b0; bus.sysrdy = 1'b0; bus.clr_req = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++;
        if (dut_all !== 15'h0000 || dut_all !== mdl_all) begin
            n_bad++;
            $display("FAIL reset all=%h exp=0 model=%h", dut_all, mdl_all);
        end
    endtask

    task automatic test_driver();
        int g;
        bus.drv_flt_n[2] = 1'b0;
        tick_edges(4);
        bus.drv_flt_n[2] = 1'b1;
        tick_edges(1);
        n_cmp++;
        if (bus.fault3 !== 1'b0) begin n_bad++; $display("FAIL drv_4tick fault3=%b exp=0", bus.fault3); end
        for (int r = 0; r < 2; r++) begin
            g = $urandom_range(1, 4);
            bus.drv_flt_n[2] = 1'b0;
            tick_edges(g);
            bus.drv_flt_n[2] = 1'b1;
            tick_edges(1);
            n_cmp++;
            if (bus.fault3 !== 1'b0 || dut_all !== mdl_all) begin
                n_bad++; $display("FAIL drv_glitch len=%0d all=%h exp=%h", g, dut_all, mdl_all);
            end
        end
        bus.drv_flt_n[2] = 1'b0;
        tick_edges(5);
        n_cmp++;
        if (bus.fault3 !== 1'b1 || bus.trip !== 1'b0 || bus.first_fault !== 4'd3) begin
            n_bad++;
            $display("FAIL drv_latch f3=%b trip=%b ff=%0d exp 1/0/3", bus.fault3, bus.trip, bus.first_fault);
        end
        cyc();
        n_cmp++;
        if (bus.trip !== 1'b1 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL drv_trip trip=%b all=%h exp trip=1 all=%h", bus.trip, dut_all, mdl_all);
        end
        bus.drv_flt_n[2] = 1'b1;
        clear_faults("drv");
    endtask

    task automatic test_dcbus();
        bus.sysrdy = 1'b0;
        bus.vdc = 12'd3500;
        tick_edges(10);
        n_cmp++;
        if (bus.ov_fault !== 1'b0) begin n_bad++; $display("FAIL ov_at_th ov=%b exp=0", bus.ov_fault); end
        bus.vdc = 12'd3501;
        tick_edges(5);
        n_cmp++;
        if (bus.ov_fault !== 1'b1 || bus.first_fault !== 4'd5 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL ov_latch all=%h exp=%h ff=%0d exp ff=5", dut_all, mdl_all, bus.first_fault);
        end
        bus.vdc = 12'd2000;
        clear_faults("ov");
        bus.vdc = 12'd1200; bus.sysrdy = 1'b1;
        tick_edges(8);
        n_cmp++;
        if (bus.uv_fault !== 1'b0) begin n_bad++; $display("FAIL uv_at_th uv=%b exp=0", bus.uv_fault); end
        bus.sysrdy = 1'b0; bus.vdc = 12'd1100;
        tick_edges(20);
        n_cmp++;
        if (bus.uv_fault !== 1'b0) begin n_bad++; $display("FAIL uv_masked uv=%b exp=0", bus.uv_fault); end
        bus.sysrdy = 1'b1;
        tick_edges(4);
        n_cmp++;
        if (bus.uv_fault !== 1'b0) begin n_bad++; $display("FAIL uv_4tick uv=%b exp=0", bus.uv_fault); end
        tick_edges(1);
        n_cmp++;
        if (bus.uv_fault !== 1'b1 || bus.first_fault !== 4'd6 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL uv_latch all=%h exp=%h", dut_all, mdl_all);
        end
        bus.vdc = 12'd2000; bus.sysrdy = 1'b0;
        clear_faults("uv");
    endtask

    task automatic test_comm();
        bus.sysrdy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick_edges($urandom_range(30, 40));
            bus.hb = 1'b1; cyc(); bus.hb = 1'b0;
            n_cmp++;
            if (bus.call_fault !== 1'b0 || dut_all !== mdl_all) begin
                n_bad++; $display("FAIL comm_hb r=%0d all=%h exp=%h", r, dut_all, mdl_all);
            end
        end
        tick_edges(20);
        while (bus.tri_200us != 13'd1) cyc();
        bus.hb = 1'b1; cyc(); bus.hb = 1'b0;
        tick_edges(49);
        n_cmp++;
        if (bus.call_fault !== 1'b0) begin n_bad++; $display("FAIL comm_49 call=%b exp=0", bus.call_fault); end
        tick_edges(1);
        n_cmp++;
        if (bus.call_fault !== 1'b1 || bus.first_fault !== 4'd8 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL comm_50 all=%h exp=%h", dut_all, mdl_all);
        end
        bus.sysrdy = 1'b0;
        clear_faults("comm");
    endtask

    task automatic test_simultaneous();
        bus.tem_n = 1'b0; bus.drv_flt_n[0] = 1'b0;
        tick_edges(4);
        n_cmp++;
        if (dut_lat !== 8'h00) begin n_bad++; $display("FAIL simul_4tick lat=%h exp=00", dut_lat); end
        tick_edges(1);
        n_cmp++;
        if (dut_lat !== 8'h41 || bus.first_fault !== 4'd1) begin
            n_bad++; $display("FAIL simul_latch lat=%h ff=%0d exp lat=41 ff=1", dut_lat, bus.first_fault);
        end
        cyc();
        n_cmp++;
        if (bus.trip !== 1'b1 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL simul_trip all=%h exp=%h", dut_all, mdl_all);
        end
    endtask

    task automatic test_clear();
        bus.drv_flt_n[0] = 1'b1;
        tick_edges(1);
        bus.clr_req = 1'b1; cyc(); bus.clr_req = 1'b0;
        n_cmp++;
        if (bus.clr_nack !== 1'b1 || bus.clr_ack !== 1'b0 || dut_lat !== 8'h41) begin
            n_bad++;
            $display("FAIL clr_nack nack=%b ack=%b lat=%h exp 1/0/41", bus.clr_nack, bus.clr_ack, dut_lat);
        end
        cyc();
        n_cmp++;
        if (bus.clr_nack !== 1'b0 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL clr_nack_pulse all=%h exp=%h", dut_all, mdl_all);
        end
        bus.tem_n = 1'b1;
        clear_faults("clr");
        bus.clr_req = 1'b1; cyc(); bus.clr_req = 1'b0;
        n_cmp++;
        if ({bus.clr_ack, bus.clr_nack} !== 2'b00) begin
            n_bad++; $display("FAIL clr_in_run ack/nack=%b%b exp=00", bus.clr_ack, bus.clr_nack);
        end
    endtask

    task automatic test_rst_mid();
        bus.drv_flt_n[1] = 1'b0;
        tick_edges(2);
        bus.vdc = 12'd3600;
        tick_edges(3);
        cyc();
        n_cmp++;
        if (bus.fault2 !== 1'b1 || bus.trip !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre f2=%b trip=%b exp 1/1", bus.fault2, bus.trip);
        end
        rst = 1'b1; bus.drv_flt_n = 4'hF;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (dut_all !== 15'h0000 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL rst_mid all=%h exp=0", dut_all);
        end
        tick_edges(3);
        bus.vdc = 12'd2000;
        tick_edges(2);
        n_cmp++;
        if (bus.ov_fault !== 1'b0 || dut_all !== mdl_all) begin
            n_bad++; $display("FAIL rst_3tick all=%h exp=%h", dut_all, mdl_all);
        end
    endtask

    task automatic test_random();
        int b;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                b = $urandom_range(0, 3);
                bus.drv_flt_n[b] = ~bus.drv_flt_n[b];
            end
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 4))
                    0:       bus.vdc = 12'($urandom_range(3501, 4095));
                    1:       bus.vdc = 12'($urandom_range(0, 1199));
                    2:       bus.vdc = 12'd3500;
                    3:       bus.vdc = 12'd1200;
                    default: bus.vdc = 12'($urandom_range(1200, 3500));
                endcase
            end
            if ($urandom_range(0, 59) == 0)  bus.tem_n  = ~bus.tem_n;
            if ($urandom_range(0, 399) == 0) bus.sysrdy = ~bus.sysrdy;
            bus.hb      = ($urandom_range(0, 299) == 0);
            bus.clr_req = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 1499) == 0);
            cyc();
            n_cmp++;
            if (dut_all !== mdl_all) begin
                n_bad++; $display("FAIL random k=%0d all=%h exp=%h", k, dut_all, mdl_all);
            end
        end
        rst = 1'b0; bus.hb = 1'b0; bus.clr_req = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        test_reset();
        test_driver();
        test_dcbus();
        test_comm();
        test_simultaneous();
        test_clear();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
